aes_block_responder: RTL and testbench

- Data-side counterpart of the MCU in the AES encrypt/decrypt datapath.
- The MCU offers receive-FIFO words with read_fifo. This block answers with accepted and packs words into one cipher block.
- It launches the cipher core, then unpacks the result into the transmit FIFO and reports data_done back to the MCU.
- It sits between the Rx FIFO, the AES core and the Tx FIFO, and owns the word/block conversion.

---
 rtl/aes_block_responder.sv | 115 +++++++++++
 tb/tb_aes_block_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_responder.sv
// aes_block_responder
//   Word/block converter between the Rx FIFO, the AES core and the Tx FIFO.
//   Collects WORDS words from the MCU (MSW first) into one cipher block and
//   launches the core. When the core returns its result, the block streams
//   the result words out to the Tx FIFO and then pulses data_done.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   read_fifo, rx_data  : MCU word offer; transfers on read_fifo & accepted
//   is_encrypt          : mode, sampled on word 0 of each block
//   accepted            : high while collecting words
//   core_start          : one-cycle core launch pulse
//   core_mode           : mode latched for the current block
//   core_block          : assembled input block
//   core_done           : core result strobe
//   core_result         : core output block
//   fullTx              : Tx FIFO full; stalls the drain
//   trans_req, tx_data  : Tx word offer; enqueued on trans_req & !fullTx
//   data_done           : one-cycle pulse after the last result word
//   status_bits         : current state encoding
module aes_block_responder #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_fifo,
  input  logic [WORD_W-1:0]        rx_data,
  input  logic                     is_encrypt,
  output logic                     accepted,
  output logic                     core_start,
  output logic                     core_mode,
  output logic [WORD_W*WORDS-1:0]  core_block,
  input  logic                     core_done,
  input  logic [WORD_W*WORDS-1:0]  core_result,
  input  logic                     fullTx,
  output logic                     trans_req,
  output logic [WORD_W-1:0]        tx_data,
  output logic                     data_done,
  output logic [2:0]               status_bits
);
  localparam int BW = WORD_W * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    START     = 3'd1,
    WAIT_CORE = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_block;
  logic [BW-1:0]   r_shift;
  logic            r_mode;
  logic            w_last;

  assign w_last = (r_cnt == CW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_block <= '0;
      r_shift <= '0;
      r_mode  <= 1'b1;
    end else begin
      unique case (r_state)
        COLLECT: if (read_fifo) begin
          // Slot 0 is the most significant word of the block.
          for (int i = 0; i < WORDS; i++)
            if (r_cnt == CW'(i))
              r_block[(WORDS-1-i)*WORD_W +: WORD_W] <= rx_data;
          if (r_cnt == '0) r_mode <= is_encrypt;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        START: r_state <= WAIT_CORE;
        WAIT_CORE: if (core_done) begin
          r_shift <= core_result;
          r_state <= DRAIN;
        end
        DRAIN: if (!fullTx) begin
          // Head word goes out; the next one moves into the top slot.
          r_shift <= {r_shift[BW-WORD_W-1:0], {WORD_W{1'b0}}};
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
  end

  // Handshake outputs depend on the state register only.
  assign accepted    = (r_state == COLLECT);
  assign core_start  = (r_state == START);
  assign trans_req   = (r_state == DRAIN);
  assign data_done   = (r_state == DONE);
  assign status_bits = r_state;
  assign core_mode   = r_mode;
  assign core_block  = r_block;
  assign tx_data     = r_shift[BW-1 -: WORD_W];

endmodule

// File: tb/tb_aes_block_responder.sv
module tb_aes_block_responder;
  logic         clk = 1'b0;
  logic         reset, read_fifo, is_encrypt, core_done, fullTx;
  logic [31:0]  rx_data;
  logic [127:0] core_result;
  logic         accepted, core_start, core_mode, trans_req, data_done;
  logic [127:0] core_block;
  logic [31:0]  tx_data;
  logic [2:0]   status_bits;

  aes_block_responder #(.WORD_W(32), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .read_fifo(read_fifo), .rx_data(rx_data),
    .is_encrypt(is_encrypt), .accepted(accepted), .core_start(core_start),
    .core_mode(core_mode), .core_block(core_block), .core_done(core_done),
    .core_result(core_result), .fullTx(fullTx), .trans_req(trans_req),
    .tx_data(tx_data), .data_done(data_done), .status_bits(status_bits)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_enq = -10;
  int exp_done = 0;
  logic [128:0] exp_blk[$];   // {mode, block}
  logic [31:0]  exp_tx[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      if (exp_blk.size() == 0) chk("unexpected_core_start", 1, 0);
      else begin
        logic [128:0] e;
        e = exp_blk.pop_front();
        chk("core_block", core_block, e[127:0]);
        chk("core_mode", {127'd0, core_mode}, {127'd0, e[128]});
      end
    end
    if (data_done) begin
      if (exp_done == 0) chk("unexpected_data_done", 1, 0);
      else begin
        exp_done--;
        chk("data_done_timing", cyc, last_enq + 1);
        chk("tx_words_left_at_done", exp_tx.size(), 0);
      end
    end
    if (trans_req && !fullTx) begin
      last_enq = cyc;
      if (exp_tx.size() == 0) chk("unexpected_tx_word", {96'd0, tx_data}, 0);
      else chk("tx_data", {96'd0, tx_data}, {96'd0, exp_tx.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // enc[i] is the is_encrypt value presented with word i.
  task automatic send_block(input logic [127:0] blk, input logic [3:0] enc);
    for (int i = 0; i < 4; i++) begin
      read_fifo  = 1'b1;
      rx_data    = blk[127-32*i -: 32];
      is_encrypt = enc[i];
      tick();
    end
    read_fifo = 1'b0;
  endtask

  task automatic expect_result(input logic [127:0] r, input int nwords, input bit done);
    for (int i = 0; i < nwords; i++) exp_tx.push_back(r[127-32*i -: 32]);
    if (done) exp_done++;
  endtask

  task automatic core_respond(input logic [127:0] r, input int lat);
    repeat (lat) tick();
    core_done = 1'b1; core_result = r;
    tick();
    core_done = 1'b0; core_result = '0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string nm);
    int k = 0;
    while (status_bits !== s && k < max) begin tick(); k++; end
    chk(nm, {125'd0, status_bits}, {125'd0, s});
  endtask

  localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] RES1 = 128'h3925841D_02DC09FB_DC118597_196A0B32;
  localparam logic [127:0] BLK2 = 128'h00102030_40506070_8090A0B0_C0D0E0F0;
  localparam logic [127:0] RES2 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  localparam logic [127:0] BLK3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] RES3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] RES4 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
  localparam logic [127:0] JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

  initial begin
    reset = 1'b1; read_fifo = 1'b0; rx_data = '0; is_encrypt = 1'b0;
    core_done = 1'b0; core_result = '0; fullTx = 1'b0;
    tick(); tick();
    chk("rst_accepted",   {127'd0, accepted},   1);
    chk("rst_trans_req",  {127'd0, trans_req},  0);
    chk("rst_core_start", {127'd0, core_start}, 0);
    chk("rst_data_done",  {127'd0, data_done},  0);
    chk("rst_status",     {125'd0, status_bits}, 0);
    chk("rst_tx_data",    {96'd0, tx_data},     0);
    chk("rst_core_mode",  {127'd0, core_mode},  1);
    reset = 1'b0;
    tick();

    // Block 1: packing order, start latency, word ignored in WAIT_CORE.
    exp_blk.push_back({1'b1, BLK1});
    send_block(BLK1, 4'b1111);
    chk("start_latency", {127'd0, core_start}, 1);
    chk("status_start", {125'd0, status_bits}, 1);
    tick();
    chk("status_wait", {125'd0, status_bits}, 2);
    read_fifo = 1'b1; rx_data = 32'hDEADBEEF;
    chk("accepted_in_wait", {127'd0, accepted}, 0);
    tick();
    read_fifo = 1'b0;
    chk("status_wait_hold", {125'd0, status_bits}, 2);
    expect_result(RES1, 4, 1);
    core_respond(RES1, 2);
    wait_state(3'd0, 20, "blk1_back_to_collect");

    // Spurious core_done while collecting.
    core_done = 1'b1; core_result = JUNK;
    tick();
    core_done = 1'b0;
    chk("spur_collect_status", {125'd0, status_bits}, 0);
    chk("spur_collect_treq", {127'd0, trans_req}, 0);

    // Block 2: mode latched on word 0; spurious done in START; Tx stall.
    exp_blk.push_back({1'b0, BLK2});
    send_block(BLK2, 4'b1100);
    core_done = 1'b1; core_result = JUNK;   // sampled while in START
    tick();
    core_done = 1'b0;
    chk("spur_start_status", {125'd0, status_bits}, 2);
    tick();
    chk("spur_start_stays_wait", {125'd0, status_bits}, 2);
    expect_result(RES2, 4, 1);
    core_respond(RES2, 8);
    tick();                                  // word 0 enqueued
    fullTx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_tx_data", {96'd0, tx_data}, 128'h6A7B0430);
      chk("stall_status", {125'd0, status_bits}, 3);
      tick();
    end
    fullTx = 1'b0;
    wait_state(3'd0, 20, "blk2_back_to_collect");

    // Block 3: reset during DRAIN after two words.
    exp_blk.push_back({1'b1, BLK3});
    send_block(BLK3, 4'b1111);
    expect_result(RES3, 2, 0);
    core_respond(RES3, 4);
    tick(); tick();
    fullTx = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; fullTx = 1'b0;
    chk("midrst_status", {125'd0, status_bits}, 0);
    chk("midrst_trans_req", {127'd0, trans_req}, 0);
    chk("midrst_accepted", {127'd0, accepted}, 1);
    chk("midrst_tx_data", {96'd0, tx_data}, 0);
    repeat (3) begin
      chk("midrst_no_done", {127'd0, data_done}, 0);
      tick();
    end

    // Block 4: full block after the abort.
    exp_blk.push_back({1'b0, BLK4});
    send_block(BLK4, 4'b0000);
    expect_result(RES4, 4, 1);
    core_respond(RES4, 5);
    wait_state(3'd0, 20, "blk4_back_to_collect");
    tick(); tick();

    chk("blk_queue_empty", exp_blk.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("done_pending", exp_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
